// File: rtl/wb_divisor_regs_if.sv
// Wishbone pipelined bus bundle between a bus master and the divisor register bank.
interface wb_divisor_regs_if;
  logic [15:0] ADR_I;
  logic [15:0] DAT_I;
  logic [15:0] DAT_O;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ACK_O;
  logic        STALL_O;

  modport master (
    output ADR_I, DAT_I, CYC_I, STB_I, WE_I,
    input  DAT_O, ACK_O, STALL_O
  );

  modport slave (
    input  ADR_I, DAT_I, CYC_I, STB_I, WE_I,
    output DAT_O, ACK_O, STALL_O
  );
endinterface

// File: rtl/wb_divisor_regs.sv
// Divisor register bank: shadow/active 32-bit divisor, coherent commit outside bus cycles,
// and a divisor_update pulse with guaranteed high and low widths.
module wb_divisor_regs #(
  parameter logic [15:0] BASE_ADDR    = 16'h400A,
  parameter int unsigned UPDATE_HOLD  = 4,
  parameter int unsigned UPDATE_GAP   = 4,
  parameter int unsigned READ_TIMEOUT = 1024
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  wb_divisor_regs_if.slave        wb,
  input  logic                    dsp_wr,
  input  logic [31:0]             dsp_div,
  output logic                    divisor_update,
  output logic                    update_pending
);

  localparam int unsigned HoldW = $clog2(UPDATE_HOLD) + 1;
  localparam int unsigned GapW  = $clog2(UPDATE_GAP) + 1;
  localparam int unsigned TmoW  = $clog2(READ_TIMEOUT) + 1;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(UPDATE_HOLD - 1);
  localparam logic [GapW-1:0]  GapMax   = GapW'(UPDATE_GAP);
  localparam logic [GapW-1:0]  GapLast  = GapW'(UPDATE_GAP - 1);
  localparam logic [TmoW-1:0]  TmoMax   = TmoW'(READ_TIMEOUT);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(READ_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWaitBus, StPulse, StGap} state_e;

  state_e           state_q, state_d;
  logic [31:0]      active_q, active_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             upd_q, upd_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             hi_read_q, hi_read_d;
  logic             ack_q, ack_d;
  logic             ack_hi_q, ack_hi_d;
  logic [15:0]      dat_q, dat_d;

  logic        accept;
  logic        commit;
  logic        hi_read_now;
  logic [15:0] offset;
  logic [15:0] rdata;

  // The DSP side always wins: any bus request in a dsp_wr cycle is stalled and retried.
  assign wb.STALL_O     = dsp_wr;
  assign accept         = wb.CYC_I & wb.STB_I & ~wb.STALL_O;
  assign offset         = wb.ADR_I - BASE_ADDR;
  assign hi_read_now    = hi_read_q | (ack_q & ack_hi_q);

  always_comb begin
    rdata = '0;
    case (offset)
      16'd0:   rdata = active_q[15:0];
      16'd1:   rdata = active_q[31:16];
      16'd2:   rdata = {13'b0, state_q == StGap, upd_q, pending_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    upd_d     = upd_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    hi_read_d = hi_read_now;
    ack_d     = accept;
    ack_hi_d  = accept & ~wb.WE_I & (offset == 16'd1);
    dat_d     = (accept & ~wb.WE_I) ? rdata : '0;
    commit    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          if (!wb.CYC_I) commit = 1'b1;
          else           state_d = StWaitBus;
        end
      end
      StWaitBus: begin
        if (!wb.CYC_I) commit = 1'b1;
      end
      StPulse: begin
        if (hold_q >= HoldLast) begin
          state_d = StGap;
          upd_d   = 1'b0;
          gap_d   = '0;
          tmo_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q != GapMax) gap_d = gap_q + 1'b1;
        if (tmo_q != TmoMax) tmo_d = tmo_q + 1'b1;
        if ((gap_q >= GapLast) && (hi_read_now || (tmo_q >= TmoLast))) state_d = StIdle;
      end
    endcase

    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      state_d   = StPulse;
      upd_d     = 1'b1;
      hold_d    = '0;
      hi_read_d = 1'b0;
    end

    if (accept && wb.WE_I) begin
      case (offset)
        16'd0:   shadow_d[15:0]  = wb.DAT_I;
        16'd1:   shadow_d[31:16] = wb.DAT_I;
        16'd2:   if (wb.DAT_I[0]) pending_d = 1'b1;
        default: ;
      endcase
    end

    // A DSP load during a commit re-arms pending so the newer value gets its own pulse.
    if (dsp_wr) begin
      shadow_d  = dsp_div;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= StIdle;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
      hi_read_q <= 1'b0;
      ack_q     <= 1'b0;
      ack_hi_q  <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      hi_read_q <= hi_read_d;
      ack_q     <= ack_d;
      ack_hi_q  <= ack_hi_d;
      dat_q     <= dat_d;
    end
  end

  assign wb.ACK_O       = ack_q;
  assign wb.DAT_O       = dat_q;
  assign divisor_update = upd_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_wb_divisor_regs.sv
// Directed bench for wb_divisor_regs; all stimulus and sampling on the falling clock edge.
module tb_wb_divisor_regs;
  logic        clk = 1'b0;
  logic        rst;
  logic        dsp_wr;
  logic [31:0] dsp_div;
  logic        upd;
  logic        pending;

  int n_checks = 0;
  int n_fail   = 0;

  wb_divisor_regs_if wb ();

  wb_divisor_regs dut (
    .CLK_I          (clk),
    .RST_I          (rst),
    .wb             (wb),
    .dsp_wr         (dsp_wr),
    .dsp_div        (dsp_div),
    .divisor_update (upd),
    .update_pending (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge where ACK_O is sampled.
  task automatic wb_read(input string tag, input logic [15:0] a, output logic [15:0] d);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = a;
    @(negedge clk);
    check({tag, "_ack"}, {31'b0, wb.ACK_O}, 32'd1);
    d = wb.DAT_O;
    wb.STB_I = 1'b0; wb.CYC_I = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [15:0] a, input logic [15:0] v);
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b1; wb.ADR_I = a; wb.DAT_I = v;
    @(negedge clk);
    check({tag, "_ack"}, {31'b0, wb.ACK_O}, 32'd1);
    wb.STB_I = 1'b0; wb.CYC_I = 1'b0; wb.WE_I = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    wb_read(tag, a, d);
    check(tag, {16'b0, d}, {16'b0, exp});
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    while (!upd && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, upd}, 32'd1);
  endtask

  // Let the current pulse finish, read DIV_HI so the gap can close, then idle.
  task automatic finish_pulse();
    int n = 0;
    logic [15:0] d;
    while (upd && n < 20) begin
      @(negedge clk);
      n++;
    end
    wb_read("fin_hi", 16'h400B, d);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] exp_prev;
    logic [15:0] d;

    rst = 1'b1; dsp_wr = 1'b0; dsp_div = '0;
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.ADR_I = '0; wb.DAT_I = '0;
    exp_prev = '0;
    repeat (2) @(negedge clk);

    // 1: reset state and zero reads
    check("rst_ack", {31'b0, wb.ACK_O}, 32'd0);
    check("rst_dat", {16'b0, wb.DAT_O}, 32'd0);
    check("rst_upd", {31'b0, upd}, 32'd0);
    check("rst_pend", {31'b0, pending}, 32'd0);
    check("rst_stall", {31'b0, wb.STALL_O}, 32'd0);
    rst = 1'b0;
    read_chk("t1_lo", 16'h400A, 16'h0000);
    read_chk("t1_hi", 16'h400B, 16'h0000);
    read_chk("t1_st", 16'h400C, 16'h0000);
    check("t1_upd", {31'b0, upd}, 32'd0);

    // 2: DSP load with bus idle commits and pulses for 4 cycles
    dsp_wr = 1'b1; dsp_div = 32'h0001_86A0;
    #1 check("t2_stall", {31'b0, wb.STALL_O}, 32'd1);
    @(negedge clk);
    dsp_wr = 1'b0;
    check("t2_pend", {31'b0, pending}, 32'd1);
    check("t2_upd0", {31'b0, upd}, 32'd0);
    @(negedge clk);
    check("t2_upd1", {31'b0, upd}, 32'd1);
    check("t2_pend0", {31'b0, pending}, 32'd0);
    n = 0;
    while (upd && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_hold", n, 32'd4);
    read_chk("t2_st_gap", 16'h400C, 16'h0004);
    read_chk("t2_lo", 16'h400A, 16'h86A0);
    read_chk("t2_hi", 16'h400B, 16'h0001);
    repeat (8) @(negedge clk);
    read_chk("t2_st_idle", 16'h400C, 16'h0000);

    // 3: long bus cycle with reads; DSP load must wait for CYC_I to fall
    wb.CYC_I = 1'b1; wb.WE_I = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0 && k <= 20) begin
        check("t3_ack", {31'b0, wb.ACK_O}, 32'd1);
        check("t3_dat", {16'b0, wb.DAT_O}, {16'b0, exp_prev});
      end
      if (k > 21) check("t3_noupd", {31'b0, upd}, 32'd0);
      if (k == 25) check("t3_pend", {31'b0, pending}, 32'd1);
      if (k < 20) begin
        wb.STB_I = 1'b1;
        wb.ADR_I = (k % 2 == 1) ? 16'h400B : 16'h400A;
        exp_prev = (k % 2 == 1) ? 16'h0001 : 16'h86A0;
      end else begin
        wb.STB_I = 1'b0;
      end
      dsp_wr = (k == 20); dsp_div = 32'h0000_0032;
      @(negedge clk);
    end
    wb.CYC_I = 1'b0;
    @(negedge clk);
    check("t3_upd", {31'b0, upd}, 32'd1);
    finish_pulse();
    read_chk("t3_lo", 16'h400A, 16'h0032);

    // 4: three pipelined reads, then a read colliding with dsp_wr is stalled and retried
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = 16'h400A;
    @(negedge clk);
    check("t4_ack0", {31'b0, wb.ACK_O}, 32'd1);
    check("t4_dat0", {16'b0, wb.DAT_O}, 32'h0032);
    wb.ADR_I = 16'h400B;
    @(negedge clk);
    check("t4_ack1", {31'b0, wb.ACK_O}, 32'd1);
    check("t4_dat1", {16'b0, wb.DAT_O}, 32'h0000);
    wb.ADR_I = 16'h400F;
    @(negedge clk);
    check("t4_ack2", {31'b0, wb.ACK_O}, 32'd1);
    check("t4_dat2", {16'b0, wb.DAT_O}, 32'h0000);
    wb.ADR_I = 16'h400A; dsp_wr = 1'b1; dsp_div = 32'h0000_0077;
    #1 check("t4_stall", {31'b0, wb.STALL_O}, 32'd1);
    @(negedge clk);
    dsp_wr = 1'b0;
    check("t4_noack", {31'b0, wb.ACK_O}, 32'd0);
    @(negedge clk);
    check("t4_retry_ack", {31'b0, wb.ACK_O}, 32'd1);
    check("t4_retry_dat", {16'b0, wb.DAT_O}, 32'h0032);
    wb.STB_I = 1'b0; wb.CYC_I = 1'b0;
    wait_rise("t4_rise");
    read_chk("t4_hi77", 16'h400B, 16'h0000);
    // load during the pulse: must wait out the gap before its own pulse
    dsp_wr = 1'b1; dsp_div = 32'h0000_0088;
    @(negedge clk);
    dsp_wr = 1'b0;
    n = 0;
    while (upd && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!upd && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_gap_width", {31'b0, (n >= 4 && n <= 6)}, 32'd1);
    finish_pulse();
    read_chk("t4_lo88", 16'h400A, 16'h0088);

    // 5: two DSP loads in the gap with no DIV_HI read: one pulse after the read timeout
    dsp_wr = 1'b1; dsp_div = 32'h0000_0099;
    @(negedge clk);
    dsp_wr = 1'b0;
    wait_rise("t5_rise0");
    n = 0;
    while (upd && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!upd && n < 3000) begin
      dsp_wr = (n == 0) || (n == 2);
      dsp_div = (n == 0) ? 32'h0000_0010 : 32'h0000_0020;
      if (n == 5) check("t5_pend", {31'b0, pending}, 32'd1);
      @(negedge clk);
      dsp_wr = 1'b0;
      n++;
    end
    check("t5_timeout", {31'b0, (n >= 1024 && n <= 1026)}, 32'd1);
    read_chk("t5_lo", 16'h400A, 16'h0020);
    read_chk("t5_hi", 16'h400B, 16'h0000);
    finish_pulse();
    check("t5_upd_end", {31'b0, upd}, 32'd0);
    check("t5_pend_end", {31'b0, pending}, 32'd0);
    read_chk("t5_st", 16'h400C, 16'h0000);

    // 6: bus writes stage and trigger a commit; reset mid-pulse clears everything
    wb_write("t6_wlo", 16'h400A, 16'h1234);
    wb_write("t6_whi", 16'h400B, 16'h0000);
    wb_write("t6_wst", 16'h400C, 16'h0001);
    wait_rise("t6_rise");
    finish_pulse();
    read_chk("t6_lo", 16'h400A, 16'h1234);
    read_chk("t6_hi", 16'h400B, 16'h0000);
    wb_write("t6_wst2", 16'h400C, 16'h0001);
    wait_rise("t6_rise2");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_upd", {31'b0, upd}, 32'd0);
    check("t6_rst_pend", {31'b0, pending}, 32'd0);
    rst = 1'b0;
    read_chk("t6_rst_lo", 16'h400A, 16'h0000);
    read_chk("t6_rst_hi", 16'h400B, 16'h0000);
    read_chk("t6_rst_st", 16'h400C, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_divisor_regs.md
Name: wb_divisor_regs

Overview:
- Wishbone pipelined slave register bank sitting directly upstream of the clock-divisor master.
- Holds the 32-bit divisor as two 16-bit words at 0x400A (low) and 0x400B (high); the divisor master reads these after sensing a rising edge on divisor_update.
- Takes new divisor values from the DSP side or from bus writes, and commits them coherently only while no bus cycle is active.
- Generates the divisor_update pulse with guaranteed high and low widths.

Parameters:
- BASE_ADDR, 16'h400A, address of DIV_LO; DIV_HI = BASE+1, STATUS = BASE+2.
- UPDATE_HOLD, 4, cycles divisor_update stays high (min 2).
- UPDATE_GAP, 4, minimum cycles divisor_update stays low after a pulse.
- READ_TIMEOUT, 1024, max cycles in GAP waiting for the DIV_HI read.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  synchronous active-high reset.
- ADR_I  in  16  Wishbone address.
- DAT_I  in  16  Wishbone write data.
- DAT_O  out  16  Wishbone read data, valid with ACK_O.
- CYC_I  in  1  bus cycle.
- STB_I  in  1  strobe, one request per cycle (pipelined mode).
- WE_I  in  1  1 = write, 0 = read.
- ACK_O  out  1  acknowledge, one per accepted request.
- STALL_O  out  1  slave cannot accept a request this cycle.
- dsp_wr  in  1  single-cycle strobe loading dsp_div into the shadow register.
- dsp_div  in  32  new divisor from the DSP.
- divisor_update  out  1  divisor-ready pulse to the divisor master.
- update_pending  out  1  a shadow value is waiting to be committed or delivered.

Behaviour:

Reset: on RST_I=1 at a clock edge:
- active, shadow and DAT_O all clear to 0; ACK_O=0, STALL_O=0, divisor_update=0, update_pending=0.
- FSM goes to IDLE and all counters clear.
- Any in-flight ack is dropped.

Bus acceptance and acknowledge:
- A request is accepted when CYC_I & STB_I & !STALL_O.
- ACK_O=1 exactly one cycle after acceptance, with DAT_O registered on that same cycle.
- Back-to-back requests are acked in order on consecutive cycles.
- ACK_O is never asserted when CYC_I was low at acceptance.
- STALL_O=1 only on a cycle in which dsp_wr=1, so the DSP write always wins.

Read decode:
- Offset 0 returns active[15:0]; offset 1 returns active[31:16].
- Offset 2 (STATUS) returns {13'b0, fsm_in_gap, divisor_update, update_pending}.
- Any other address is acked with DAT_O=0.

Write decode:
- Offset 0 writes shadow[15:0]; offset 1 writes shadow[31:16].
- Offset 2 with DAT_I[0]=1 sets update_pending.
- Writes to any other address are acked and ignored.
- Writes never modify the active register directly.

DSP side:
- dsp_wr loads shadow <= dsp_div and sets update_pending on the same cycle.
- dsp_wr while pending overwrites the shadow; only one pulse is produced, carrying the latest value.

FSM:
- IDLE: if update_pending and CYC_I=0, then active <= shadow, clear pending, go to PULSE. If update_pending and CYC_I=1, go to WAIT_BUS.
- WAIT_BUS: stay while CYC_I=1. When CYC_I=0, commit as above and go to PULSE.
- PULSE: divisor_update=1 for exactly UPDATE_HOLD cycles, then go to GAP.
- GAP: divisor_update=0. Exit to IDLE when at least UPDATE_GAP cycles have elapsed AND either an acked read of offset 1 occurred since entering PULSE, or READ_TIMEOUT cycles have elapsed in GAP.
- Commits are blocked in PULSE and GAP. A pending value in those states waits and is handled on return to IDLE.

Width rules:
- Hold, gap and timeout counters are sized by $clog2 of their parameter plus 1.
- Counters saturate; they never wrap.

Simultaneous events:
- dsp_wr and a bus write to the shadow in the same cycle: the bus request is stalled and retried by the master, so the DSP value lands first.
- Commit and bus-request acceptance never occur in the same cycle, because a commit requires CYC_I=0.

Test Plan:
1. Reset, then read 0x400A, 0x400B and 0x400C → each returns 0x0000, ACK one cycle after each STB, divisor_update=0.
2. dsp_wr with dsp_div=0x0001_86A0, CYC_I=0 → active commits the next cycle; divisor_update high for 4 cycles, then low for at least 4; a subsequent read pair returns 0x86A0 and 0x0001.
3. Hold CYC_I=1 for 20 cycles with reads in flight, then pulse dsp_wr=0x0000_0032 → no commit and no pulse until CYC_I falls; reads during the cycle return the old value.
4. Pipelined STB on 3 consecutive cycles to 0x400A/0x400B/0x400F → 3 in-order ACKs on consecutive cycles, returning lo, hi, 0x0000. Then dsp_wr coinciding with a 4th STB → STALL_O=1 for that cycle, and the retried request is acked.
5. Two dsp_wr (0x10 then 0x20) 2 cycles apart during GAP with no DIV_HI read → exactly one new pulse after READ_TIMEOUT elapses, and active=0x20.
6. Bus writes 0x1234 to 0x400A, 0x0000 to 0x400B, then 0x0001 to 0x400C → pulse issued and active=0x0000_1234. Asserting RST_I mid-PULSE → divisor_update=0 the next cycle and active=0.
